// File: rtl/acc_addsub_8bit.sv
// acc_addsub_8bit: 8-bit accumulator with ADD/SUB/LOAD/CLEAR ops and a
// valid/ready request/response handshake (IDLE -> EXEC -> RESP -> IDLE).
//
// Build option: define ACC_ADDSUB_SAT_EN to saturate ADD/SUB results on
// signed overflow (7F positive, 80 negative). When it is undefined, ADD/SUB
// wrap modulo 256. The port list is the same in both builds.
//
// Ports:
//   clk        - clock, all state updates on the rising edge
//   rst        - synchronous active-high reset
//   in_valid   - request present
//   in_ready   - block accepts a request (IDLE only)
//   in_op      - 00 ADD, 01 SUB, 10 LOAD, 11 CLEAR
//   in_data    - operand / load value (ignored for CLEAR)
//   out_valid  - result and flags valid (RESP)
//   out_ready  - consumer accepts the result
//   acc        - accumulator register
//   carry, overflow, zero, negative - flags of the last completed op
//   ovf_sticky - OR of overflow results since reset or CLEAR
module acc_addsub_8bit #(
  parameter logic [7:0] INIT_ACC = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [1:0] in_op,
  input  logic [7:0] in_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] acc,
  output logic       carry,
  output logic       overflow,
  output logic       zero,
  output logic       negative,
  output logic       ovf_sticky
);

  localparam int unsigned DW = 8;

  localparam logic [1:0] OP_ADD   = 2'b00;
  localparam logic [1:0] OP_SUB   = 2'b01;
  localparam logic [1:0] OP_LOAD  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } state_e;

  state_e        state_q, state_d;
  logic [1:0]    op_q, op_d;
  logic [DW-1:0] data_q, data_d;
  logic [DW-1:0] acc_q, acc_d;
  logic          carry_q, carry_d;
  logic          ovf_q, ovf_d;
  logic          zero_q, zero_d;
  logic          neg_q, neg_d;
  logic          sticky_q, sticky_d;
  logic          in_ready_q, in_ready_d;
  logic          out_valid_q, out_valid_d;

  // Add/sub cell: b inverted and carry-in set for SUB
  logic          sub;
  logic [DW-1:0] b_op;
  logic [DW:0]   sum_full;
  logic [DW-1:0] sum_low;
  logic          c_out;
  logic          c_into_msb;
  logic          add_ovf;
  logic [DW-1:0] add_res;

  always_comb begin
    sub        = (op_q == OP_SUB);
    b_op       = data_q ^ {DW{sub}};
    sum_full   = {1'b0, acc_q} + {1'b0, b_op} + (DW+1)'(sub);
    // Carry into the sign bit comes from adding only the low 7 bits
    sum_low    = {1'b0, acc_q[DW-2:0]} + {1'b0, b_op[DW-2:0]} + DW'(sub);
    c_out      = sum_full[DW];
    c_into_msb = sum_low[DW-1];
    add_ovf    = c_into_msb ^ c_out;
`ifdef ACC_ADDSUB_SAT_EN
    // Wrapped sign of 1 on overflow means two positives overflowed
    if (add_ovf) begin
      add_res = sum_full[DW-1] ? 8'h7F : 8'h80;
    end else begin
      add_res = sum_full[DW-1:0];
    end
`else
    add_res = sum_full[DW-1:0];
`endif
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    data_d      = data_q;
    acc_d       = acc_q;
    carry_d     = carry_q;
    ovf_d       = ovf_q;
    zero_d      = zero_q;
    neg_d       = neg_q;
    sticky_d    = sticky_q;
    out_valid_d = out_valid_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          op_d    = in_op;
          data_d  = in_data;
          state_d = EXEC;
        end
      end
      EXEC: begin
        unique case (op_q)
          OP_ADD: begin
            acc_d    = add_res;
            carry_d  = c_out;
            ovf_d    = add_ovf;
            sticky_d = sticky_q | add_ovf;
          end
          OP_SUB: begin
            acc_d    = add_res;
            carry_d  = ~c_out;  // borrow
            ovf_d    = add_ovf;
            sticky_d = sticky_q | add_ovf;
          end
          OP_LOAD: begin
            acc_d   = data_q;
            carry_d = 1'b0;
            ovf_d   = 1'b0;
          end
          OP_CLEAR: begin
            acc_d    = INIT_ACC;
            carry_d  = 1'b0;
            ovf_d    = 1'b0;
            sticky_d = 1'b0;
          end
          default: ;
        endcase
        zero_d      = (acc_d == '0);
        neg_d       = acc_d[DW-1];
        out_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    in_ready_d = (state_d == IDLE);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      op_q        <= OP_ADD;
      data_q      <= '0;
      acc_q       <= INIT_ACC;
      carry_q     <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
      neg_q       <= 1'b0;
      sticky_q    <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      data_q      <= data_d;
      acc_q       <= acc_d;
      carry_q     <= carry_d;
      ovf_q       <= ovf_d;
      zero_q      <= zero_d;
      neg_q       <= neg_d;
      sticky_q    <= sticky_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign acc        = acc_q;
  assign carry      = carry_q;
  assign overflow   = ovf_q;
  assign zero       = zero_q;
  assign negative   = neg_q;
  assign ovf_sticky = sticky_q;

endmodule

// File: tb/tb_acc_addsub_8bit.sv
// Directed bench for acc_addsub_8bit. Flags are compared as a 5-bit vector
// {carry, overflow, zero, negative, ovf_sticky}.
module tb_acc_addsub_8bit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [1:0] in_op = 2'b00;
  logic [7:0] in_data = 8'h00;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] acc;
  logic       carry, overflow, zero, negative, ovf_sticky;

  int checks = 0;
  int failures = 0;

  localparam logic [1:0] ADD = 2'b00, SUB = 2'b01, LOAD = 2'b10, CLR = 2'b11;

  acc_addsub_8bit #(.INIT_ACC(8'h00)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_data(in_data), .out_valid(out_valid),
    .out_ready(out_ready), .acc(acc), .carry(carry), .overflow(overflow),
    .zero(zero), .negative(negative), .ovf_sticky(ovf_sticky)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] flags();
    return {3'b000, carry, overflow, zero, negative, ovf_sticky};
  endfunction

  // Accept one op, scramble inputs during EXEC, land in RESP
  task automatic do_op(input string tag, input logic [1:0] op, input logic [7:0] data);
    chk({tag, "_in_ready"}, 8'(in_ready), 8'h01);
    in_op    = op;
    in_data  = data;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_op    = ~op;
    in_data  = ~data;
    chk({tag, "_exec_out_valid"}, 8'(out_valid), 8'h00);
    chk({tag, "_exec_in_ready"}, 8'(in_ready), 8'h00);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk({tag, "_resp_out_valid"}, 8'(out_valid), 8'h01);
  endtask

  task automatic release_resp(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_rel_out_valid"}, 8'(out_valid), 8'h00);
    chk({tag, "_rel_in_ready"}, 8'(in_ready), 8'h01);
  endtask

  task automatic op_check(input string tag, input logic [1:0] op, input logic [7:0] data,
                          input logic [7:0] exp_acc, input logic [4:0] exp_flags);
    do_op(tag, op, data);
    chk({tag, "_acc"}, acc, exp_acc);
    chk({tag, "_flags"}, flags(), {3'b000, exp_flags});
    release_resp(tag);
  endtask

  initial begin
    logic [7:0] held_acc;
    logic [7:0] held_flags;

    // Reset: two cycles
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_acc", acc, 8'h00);
    chk("rst_flags", flags(), 8'h00);
    chk("rst_out_valid", 8'(out_valid), 8'h00);
    chk("rst_in_ready", 8'(in_ready), 8'h01);

    // flags = {c, v, z, n, s}
    op_check("load7f", LOAD, 8'h7F, 8'h7F, 5'b00000);
`ifdef ACC_ADDSUB_SAT_EN
    op_check("add01_pos_ovf", ADD, 8'h01, 8'h7F, 5'b01001);
`else
    op_check("add01_pos_ovf", ADD, 8'h01, 8'h80, 5'b01011);
`endif
    op_check("clear1", CLR, 8'h55, 8'h00, 5'b00100);
    op_check("sub01_borrow", SUB, 8'h01, 8'hFF, 5'b10010);
    op_check("loadff", LOAD, 8'hFF, 8'hFF, 5'b00010);
    op_check("addff_carry", ADD, 8'h01, 8'h00, 5'b10100);
    op_check("load80", LOAD, 8'h80, 8'h80, 5'b00010);
`ifdef ACC_ADDSUB_SAT_EN
    op_check("sub01_neg_ovf", SUB, 8'h01, 8'h80, 5'b01011);
`else
    op_check("sub01_neg_ovf", SUB, 8'h01, 8'h7F, 5'b01001);
`endif
    op_check("load01_sticky", LOAD, 8'h01, 8'h01, 5'b00001);
    op_check("clear2", CLR, 8'h00, 8'h00, 5'b00100);
    op_check("sub_nb", SUB, 8'h00, 8'h00, 5'b00100);

    // Backpressure with in_valid high and in_data toggling
    op_check("load10", LOAD, 8'h10, 8'h10, 5'b00000);
    do_op("bp_add25", ADD, 8'h25);
    held_acc   = 8'h35;
    held_flags = 8'h00;
    chk("bp_acc0", acc, held_acc);
    chk("bp_flags0", flags(), held_flags);
    in_valid = 1'b1;
    in_op    = LOAD;
    for (int i = 0; i < 5; i++) begin
      in_data = (i % 2 == 0) ? 8'hAA : 8'h55;
      @(posedge clk); #1;
      chk($sformatf("bp_out_valid_%0d", i), 8'(out_valid), 8'h01);
      chk($sformatf("bp_acc_%0d", i), acc, held_acc);
      chk($sformatf("bp_flags_%0d", i), flags(), held_flags);
      chk($sformatf("bp_in_ready_%0d", i), 8'(in_ready), 8'h00);
    end
    in_valid = 1'b0;
    release_resp("bp");
    repeat (3) @(posedge clk);
    #1;
    chk("bp_no_extra_acc", acc, held_acc);
    chk("bp_no_extra_out_valid", 8'(out_valid), 8'h00);

    // Reset while in EXEC after an ADD accept
    op_check("load33", LOAD, 8'h33, 8'h33, 5'b00000);
    in_op    = ADD;
    in_data  = 8'h01;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_exec_in_ready", 8'(in_ready), 8'h01);
    chk("rst_exec_acc", acc, 8'h00);
    chk("rst_exec_flags", flags(), 8'h00);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_exec_out_valid_%0d", i), 8'(out_valid), 8'h00);
      @(posedge clk); #1;
    end

    // Reset while in RESP drops the pending result
    do_op("rst_resp_load", LOAD, 8'h9C);
    chk("rst_resp_pre_acc", acc, 8'h9C);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_resp_out_valid", 8'(out_valid), 8'h00);
    chk("rst_resp_acc", acc, 8'h00);
    chk("rst_resp_in_ready", 8'(in_ready), 8'h01);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/acc_addsub_8bit.md
ACC_ADDSUB_8BIT -- requirements
Module: acc_addsub_8bit

Interface
REQ-001 SHALL have parameter INIT_ACC, default 8'h00: accumulator value after reset and after CLEAR.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-004 SHALL have port in_valid, input, 1: request present.
REQ-005 SHALL have port in_ready, output, 1: block can accept a request.
REQ-006 SHALL have port in_op, input, 2: 00 ADD, 01 SUB, 10 LOAD, 11 CLEAR.
REQ-007 SHALL have port in_data, input, 8: operand (b of add/sub; value for LOAD; ignored for CLEAR).
REQ-008 SHALL have port out_valid, output, 1: result and flags valid.
REQ-009 SHALL have port out_ready, input, 1: consumer accepts result.
REQ-010 SHALL have port acc, output, 8: accumulator register.
REQ-011 SHALL have ports carry, overflow, zero, negative, each output, 1: flags of last completed op.
REQ-012 SHALL have port ovf_sticky, output, 1: OR of all overflow results since reset or CLEAR.

Function
REQ-013 SHALL implement FSM IDLE -> EXEC -> RESP -> IDLE; in_ready = 1 only in IDLE.
REQ-014 SHALL accept on in_valid & in_ready in IDLE; capture in_op and in_data into internal registers; go to EXEC.
REQ-015 SHALL in EXEC compute with 8-bit add/sub cell semantics: a = acc, b = in_data ^ {8{sub}}, carry-in = sub (sub = 1 for SUB only).
REQ-016 SHALL at the EXEC->RESP edge register acc and all flags; out_valid = 1 on the next cycle (result two edges after accept edge).
REQ-017 SHALL set carry = carry-out for ADD; carry = borrow (1 iff acc < in_data, unsigned) for SUB.
REQ-018 SHALL set overflow = carry into bit 7 XOR carry out of bit 7 for ADD/SUB; 0 for LOAD/CLEAR.
REQ-019 SHALL set carry = 0 for LOAD/CLEAR; LOAD writes in_data; CLEAR writes INIT_ACC and clears ovf_sticky.
REQ-020 SHALL set zero = (new acc == 0) and negative = new acc[7] for all ops.
REQ-021 SHALL hold out_valid, acc and flags stable in RESP until out_ready = 1; leave to IDLE on that edge.
REQ-022 SHALL ignore in_valid, in_op and in_data outside IDLE; post-accept input changes SHALL not affect the result.
REQ-023 SHALL wrap modulo 256 on ADD/SUB when saturation is not compiled in.

Reset
REQ-024 SHALL on rst = 1 at any edge, any state: state IDLE, acc = INIT_ACC, carry/overflow/zero/negative/ovf_sticky = 0, out_valid = 0.
REQ-025 SHALL discard an in-flight op on reset mid-EXEC or mid-RESP; no result presented.
REQ-026 SHALL drive in_ready = 1 on the first cycle after rst deasserts.

Configuration
REQ-027 SHALL use macro ACC_ADDSUB_SAT_EN: when defined, on ADD/SUB signed overflow acc saturates to 8'h7F (positive overflow) or 8'h80 (negative); flags are still computed from the unsaturated operation except zero/negative, which track saturated acc.
REQ-028 SHALL without ACC_ADDSUB_SAT_EN wrap per REQ-023; port list identical in both builds.

Verification
REQ-029 SHALL check reset: rst 2 cycles -> acc = 00, all flags 0, out_valid 0, in_ready 1.
REQ-030 SHALL check LOAD 7F, ADD 01 -> acc 80, overflow 1, negative 1, carry 0, ovf_sticky 1; SAT build: acc 7F, negative 0.
REQ-031 SHALL check CLEAR, SUB 01 -> acc FF, carry (borrow) 1, overflow 0, negative 1; LOAD FF, ADD 01 -> acc 00, carry 1, zero 1.
REQ-032 SHALL check LOAD 80, SUB 01 -> acc 7F, overflow 1; SAT build: acc 80; then CLEAR -> ovf_sticky 0, acc = INIT_ACC.
REQ-033 SHALL check backpressure: out_ready low 5 cycles in RESP with in_valid high, in_data toggling -> out_valid, acc, flags stable, in_ready 0, no extra op executed.
REQ-034 SHALL check reset in EXEC after ADD accept -> next cycle IDLE, acc = INIT_ACC, out_valid never asserted.
